// File: rtl/pwm_pkg.sv
// Shared servo/PWM definitions and pushbutton FSM state encoding.
// Also used by button_repeat_one_shot (BUTTON_AUTO_REPEAT_EN selects auto-repeat).
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_DB    = 3'd1,
        HELD_DELAY  = 3'd2,
        HELD_REPEAT = 3'd3,
        RELEASE_DB  = 3'd4
    } btn_state_t;

    // Without auto-repeat the held phase collapses onto one encoding
    localparam btn_state_t HELD = HELD_DELAY;

    // One button pulse moves the servo 5 degrees: 36 steps span 180 degrees
    localparam int unsigned MIN_DC = 45_000;
    localparam int unsigned STEP   = 1_500;
    localparam int unsigned MAX_DC = MIN_DC + 36 * STEP;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin.
// Both flops reset to RST_VAL so a released pin looks released out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_repeat_one_shot.sv
// Debounced pushbutton to one-shot pulse with optional auto-repeat.
// Define BUTTON_AUTO_REPEAT_EN to enable the repeat delay/rate behaviour.
module button_repeat_one_shot
    import pwm_pkg::*;
#(
    parameter bit          INVERT_LOGIC       = 1'b1,
    parameter int unsigned DEBOUNCE_THRESHOLD = 5000,
    parameter int unsigned REPEAT_DELAY       = 12_500_000,
    parameter int unsigned REPEAT_RATE        = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic signal,
    output logic signal_one_shot,
    output logic signal_level,
    output logic repeat_active
);

    localparam int unsigned CNT_MAX =
        max3(DEBOUNCE_THRESHOLD, REPEAT_DELAY, REPEAT_RATE);
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_THRESHOLD);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LIM  = CNT_W'(REPEAT_RATE - 1);
`endif

    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sync_q;
    logic             p;
    logic             fire;
    logic             level_d;
    logic             rpt_d;

    sync_2ff #(
        .RST_VAL (INVERT_LOGIC)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (signal),
        .q   (sync_q)
    );

    assign p = sync_q ^ INVERT_LOGIC;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        level_d = signal_level;
`ifdef BUTTON_AUTO_REPEAT_EN
        rpt_d   = repeat_active;
`else
        rpt_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                level_d = 1'b0;
                rpt_d   = 1'b0;
                if (p) begin
                    state_d = PRESS_DB;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LIM) begin
                    state_d = HELD_DELAY;
                    cnt_d   = '0;
                    fire    = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            HELD_DELAY: begin
                if (!p) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == RD_LIM) begin
                    state_d = HELD_REPEAT;
                    cnt_d   = '0;
                    fire    = 1'b1;
                    rpt_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HELD_REPEAT: begin
                if (!p) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == RR_LIM) begin
                    cnt_d   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
`else
            HELD: begin
                cnt_d = '0;
                if (!p) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CNT_ONE;
                end
            end
`endif
            RELEASE_DB: begin
                if (p) begin
                    state_d = HELD_DELAY;
                    cnt_d   = '0;
                    rpt_d   = 1'b0;
                end else if (cnt_q == DB_LIM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rpt_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
                rpt_d   = 1'b0;
            end
        endcase
    end

    // Suppressing a fire right after a pulse keeps pulses non-adjacent
    // even with REPEAT_DELAY or REPEAT_RATE of 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            signal_one_shot <= 1'b0;
            signal_level    <= 1'b0;
            repeat_active   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            signal_one_shot <= fire & ~signal_one_shot;
            signal_level    <= level_d;
            repeat_active   <= rpt_d;
        end
    end

endmodule

// File: doc/button_repeat_one_shot.md
BUTTON_REPEAT_ONE_SHOT -- requirements
Module: button_repeat_one_shot

Interface
REQ-001 Parameters SHALL be:
- INVERT_LOGIC, default 1: 1 = button pressed when pin is low.
- DEBOUNCE_THRESHOLD, default 5000: consecutive stable clk cycles needed to accept a press or a release; must be ≥1.
- REPEAT_DELAY, default 12_500_000: held cycles from the first pulse to the first repeat pulse; must be ≥1.
- REPEAT_RATE, default 2_500_000: cycles between repeat pulses; must be ≥1.

REQ-002 Ports SHALL be:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- signal  in  1  raw, asynchronous pushbutton pin.
- signal_one_shot  out  1  one-cycle pulse per accepted press and per repeat.
- signal_level  out  1  debounced pressed level.
- repeat_active  out  1  high while auto-repeating.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 signal SHALL pass through a 2-flop synchronizer. p = synchronized value XOR INVERT_LOGIC, so p=1 means pressed.

REQ-005 The FSM SHALL have exactly these states: IDLE, PRESS_DB, HELD_DELAY, HELD_REPEAT, RELEASE_DB. One shared counter, cnt, of width $clog2(max parameter)+1, is used by all states.

REQ-006 IDLE: when p=1, go to PRESS_DB with cnt=1. Otherwise cnt=0.

REQ-007 PRESS_DB:
- p=0 → IDLE, no pulse.
- cnt==DEBOUNCE_THRESHOLD with p=1 → HELD_DELAY, cnt=0, signal_one_shot=1 for one cycle, signal_level=1.
- Otherwise cnt+1.

REQ-008 Latency: the pulse SHALL be high in the cycle after clk edge DEBOUNCE_THRESHOLD+2, counted from the first edge that samples the pressed pin. The pin must stay pressed throughout.

REQ-009 HELD_DELAY: p=0 → RELEASE_DB with cnt=1. cnt==REPEAT_DELAY-1 → HELD_REPEAT, pulse, cnt=0, repeat_active=1. Otherwise cnt+1.

REQ-010 HELD_REPEAT: p=0 → RELEASE_DB with cnt=1. cnt==REPEAT_RATE-1 → pulse and cnt=0. Otherwise cnt+1.

REQ-011 RELEASE_DB:
- No pulses are generated in this state.
- p=1 → HELD_DELAY, cnt=0, repeat_active=0.
- cnt==DEBOUNCE_THRESHOLD with p=0 → IDLE, signal_level=0, repeat_active=0.
- Otherwise cnt+1.

REQ-012 Pulses SHALL never occur on consecutive cycles. Each pulse SHALL be exactly one clk cycle wide.

REQ-013 A bounce shorter than DEBOUNCE_THRESHOLD cycles SHALL produce no pulse and no change to signal_level.

Reset
REQ-014 While rst=0, the block SHALL hold:
- state=IDLE, cnt=0
- all outputs 0
- synchronizer flops at the released value (INVERT_LOGIC)

REQ-015 If the button is held while rst deasserts, no pulse SHALL occur until a full PRESS_DB completes.

REQ-016 Reset asserted mid-press or mid-repeat SHALL abort immediately, with no trailing pulse.

Configuration
REQ-017 Macro BUTTON_AUTO_REPEAT_EN:
- Defined: the full FSM including HELD_REPEAT and repeat_active behaviour.
- Undefined: HELD_DELAY and HELD_REPEAT are replaced by a single HELD state. HELD goes to RELEASE_DB on p=0, emits no further pulses, and repeat_active is tied 0. REPEAT_DELAY and REPEAT_RATE are ignored.

Structure
REQ-018 The state enum and its encoding SHALL reside in a shared package, pwm_pkg, alongside the servo constants MIN_DC, MAX_DC and STEP.

REQ-019 The synchronizer SHALL be a separate sub-module named sync_2ff, with ports clk, rst, d, q and a reset-value parameter.

REQ-020 The output pulse SHALL be directly compatible with the servo PWM block's increment and decrement inputs, which consume one pulse as one 5° step.

Verification
Bench parameters: DEBOUNCE_THRESHOLD=4, REPEAT_DELAY=20, REPEAT_RATE=8, INVERT_LOGIC=1.

REQ-021 Press held 10 cycles, then released → exactly 1 pulse at cycle 6 after the first sampled low, then signal_level falls 6 cycles after release.

REQ-022 Pin low for 3 cycles only → no pulse, signal_level stays 0.

REQ-023 Held 60 cycles → pulses at cycles 6, 26, 34, 42, 50, 58; repeat_active rises at cycle 26.

REQ-024 During repeat, pin high for 2 cycles then low again → no extra pulse; the next pulse follows after 20 cycles (HELD_DELAY restarted).

REQ-025 rst pulled low at cycle 30 while held, released at cycle 35 with the pin still low → outputs 0 during reset, next pulse at cycle 41.

REQ-026 Build without BUTTON_AUTO_REPEAT_EN, held 60 cycles → a single pulse at cycle 6 and repeat_active constant 0.
